signal_buffer_writer: RTL and testbench



---
 rtl/signal_buffer_writer_if.sv | 25 ++
 rtl/signal_buffer_writer.sv | 194 +++++++++++++++++++
 tb/tb_signal_buffer_writer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/signal_buffer_writer_if.sv
// rtl/signal_buffer_writer_if.sv - sample stream and display-RAM write bus for signal_buffer_writer
interface signal_buffer_writer_if;
  // sample pair stream (producer -> writer)
  logic        sample_valid;
  logic [11:0] sample_ch0;
  logic [11:0] sample_ch1;
  logic        sample_ready;

  // display RAM write port (writer -> RAM)
  logic        mem_wEn;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;

  // sample source / RAM side
  modport master (
    output sample_valid, sample_ch0, sample_ch1,
    input  sample_ready, mem_wEn, mem_addr, mem_data
  );

  // writer side
  modport slave (
    input  sample_valid, sample_ch0, sample_ch1,
    output sample_ready, mem_wEn, mem_addr, mem_data
  );
endinterface

// File: rtl/signal_buffer_writer.sv
// rtl/signal_buffer_writer.sv - frame-locked decimating two-channel writer into display RAM (optional SIGWR_CROSSING_EN)
module signal_buffer_writer #(
  parameter int          DEPTH      = 320,
  parameter logic [11:0] CH0_BASE   = 12'h559,
  parameter logic [11:0] CH1_BASE   = 12'h6AD,
  parameter logic [11:0] VALUE_ADDR = 12'h6A8,
  parameter int          DECIM      = 1,
  parameter logic [11:0] THRESH     = 12'h800
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_start,
  signal_buffer_writer_if.slave  bus,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCW-1:0] DC_LAST  = DCW'(DECIM - 1);
  localparam logic [8:0]     IDX_LAST = 9'(DEPTH - 1);

`ifdef SIGWR_CROSSING_EN
  typedef enum logic [2:0] {
    WAIT_FRAME, ACCEPT, WRITE_CH0, WRITE_CH1, WRITE_VALUE
  } state_t;
`else
  typedef enum logic [1:0] {
    WAIT_FRAME, ACCEPT, WRITE_CH0, WRITE_CH1
  } state_t;
`endif

  state_t state, next_state;

  logic [8:0]     idx;
  logic [DCW-1:0] dc;
  logic [11:0]    ch1_q;

`ifdef SIGWR_CROSSING_EN
  logic [11:0] ch0_q;
  logic [11:0] prev;
  logic        armed;
  logic [9:0]  cnt;
`else
  // threshold and count address only matter when the crossing detector exists
  logic unused_cfg;
  assign unused_cfg = ^{VALUE_ADDR, THRESH};
`endif

  // next values of the registered RAM write port
  logic        wen_d;
  logic [11:0] addr_d;
  logic [31:0] data_d;
  logic        done_d;

  logic        wen_q;
  logic [11:0] addr_q;
  logic [31:0] data_q;

  assign bus.sample_ready = (state == ACCEPT);
  assign bus.mem_wEn      = wen_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_data     = data_q;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= next_state;
  end

  // next state and next write-port values; the write port is loaded from the
  // transition so each write appears on the first cycle of its state
  always_comb begin
    next_state = state;
    wen_d      = 1'b0;
    addr_d     = '0;
    data_d     = '0;
    done_d     = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (frame_start) next_state = ACCEPT;
      end
      ACCEPT: begin
        if (bus.sample_valid && (dc == '0)) begin
          next_state = WRITE_CH0;
          wen_d      = 1'b1;
          addr_d     = CH0_BASE + {3'b000, idx};
          data_d     = {20'b0, bus.sample_ch0};
        end
      end
      WRITE_CH0: begin
        next_state = WRITE_CH1;
        wen_d      = 1'b1;
        addr_d     = CH1_BASE + {3'b000, idx};
        data_d     = {20'b0, ch1_q};
      end
      WRITE_CH1: begin
        if (idx == IDX_LAST) begin
`ifdef SIGWR_CROSSING_EN
          next_state = WRITE_VALUE;
          wen_d      = 1'b1;
          addr_d     = VALUE_ADDR;
          data_d     = {22'b0, cnt};
`else
          next_state = WAIT_FRAME;
          done_d     = 1'b1;
`endif
        end else begin
          next_state = ACCEPT;
        end
      end
`ifdef SIGWR_CROSSING_EN
      WRITE_VALUE: begin
        next_state = WAIT_FRAME;
        done_d     = 1'b1;
      end
`endif
      default: next_state = WAIT_FRAME;
    endcase
  end

  // registered outputs: write port, frame_done pulse and busy
  always_ff @(posedge clock) begin
    if (reset) begin
      wen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      frame_done <= done_d;
      busy       <= (next_state != WAIT_FRAME);
    end
  end

  // frame datapath: point index, decimation phase and the latched pair
  always_ff @(posedge clock) begin
    if (reset) begin
      idx   <= '0;
      dc    <= '0;
      ch1_q <= '0;
`ifdef SIGWR_CROSSING_EN
      ch0_q <= '0;
`endif
    end else begin
      case (state)
        WAIT_FRAME: begin
          if (frame_start) begin
            idx <= '0;
            dc  <= '0;
          end
        end
        ACCEPT: begin
          if (bus.sample_valid) begin
            dc <= (dc == DC_LAST) ? '0 : dc + 1'b1;
            if (dc == '0) begin
              ch1_q <= bus.sample_ch1;
`ifdef SIGWR_CROSSING_EN
              ch0_q <= bus.sample_ch0;
`endif
            end
          end
        end
        WRITE_CH1: begin
          if (idx != IDX_LAST) idx <= idx + 9'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SIGWR_CROSSING_EN
  // rising crossings of channel 0 through THRESH; the first kept sample of a
  // frame only primes prev, and the count saturates at 999
  always_ff @(posedge clock) begin
    if (reset) begin
      prev  <= '0;
      armed <= 1'b0;
      cnt   <= '0;
    end else if ((state == WAIT_FRAME) && frame_start) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (state == WRITE_CH0) begin
      if (armed && (prev < THRESH) && (ch0_q >= THRESH) && (cnt != 10'd999))
        cnt <= cnt + 10'd1;
      prev  <= ch0_q;
      armed <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_signal_buffer_writer.sv
// tb/tb_signal_buffer_writer.sv - self-checking bench for signal_buffer_writer
module tb_signal_buffer_writer;

  localparam int          DEPTH      = 320;
  localparam logic [11:0] CH0_BASE   = 12'h559;
  localparam logic [11:0] CH1_BASE   = 12'h6AD;
  localparam logic [11:0] VALUE_ADDR = 12'h6A8;
  localparam logic [11:0] THRESH     = 12'h800;
`ifdef SIGWR_CROSSING_EN
  localparam int DONE_LAT  = 2;
  localparam bit HAS_VALUE = 1'b1;
`else
  localparam int DONE_LAT  = 1;
  localparam bit HAS_VALUE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [1:0]       fs, sv;
  logic [1:0][11:0] c0, c1;
  logic [1:0]       rdy, wen, fd, bz;
  logic [1:0][11:0] addr;
  logic [1:0][31:0] data;

  signal_buffer_writer_if bus0 ();
  signal_buffer_writer_if bus1 ();

  assign bus0.sample_valid = sv[0];
  assign bus0.sample_ch0   = c0[0];
  assign bus0.sample_ch1   = c1[0];
  assign rdy[0]            = bus0.sample_ready;
  assign wen[0]            = bus0.mem_wEn;
  assign addr[0]           = bus0.mem_addr;
  assign data[0]           = bus0.mem_data;
  assign bus1.sample_valid = sv[1];
  assign bus1.sample_ch0   = c0[1];
  assign bus1.sample_ch1   = c1[1];
  assign rdy[1]            = bus1.sample_ready;
  assign wen[1]            = bus1.mem_wEn;
  assign addr[1]           = bus1.mem_addr;
  assign data[1]           = bus1.mem_data;

  signal_buffer_writer #(.DECIM(1)) dut0 (
    .clock(clock), .reset(reset), .frame_start(fs[0]), .bus(bus0),
    .frame_done(fd[0]), .busy(bz[0]));
  signal_buffer_writer #(.DECIM(4)) dut1 (
    .clock(clock), .reset(reset), .frame_start(fs[1]), .bus(bus1),
    .frame_done(fd[1]), .busy(bz[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          d;
    logic [11:0] a;
    logic [31:0] v;
    int          c;
  } wr_t;

  wr_t wlog[$];
  int  fd_d[$], fd_c[$];
  int  hs_d[$], hs_c[$];

  // observe both DUTs away from the active edge
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (wen[d] === 1'b1) wlog.push_back('{d, addr[d], data[d], cyc});
      if (fd[d] === 1'b1) begin fd_d.push_back(d); fd_c.push_back(cyc); end
      if ((sv[d] & rdy[d]) === 1'b1) begin hs_d.push_back(d); hs_c.push_back(cyc); end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int d;
    int pat;          // 0 ramp, 1 alternating 0x700/0x900 per kept point, 2 random
    bit rv;           // random sample_valid
    bit mid_fs;       // extra frame_start pulse inside the frame
    bit skip_pulse;   // frame already armed by the previous row
    bit fs_on_done;   // pulse frame_start on the frame_done cycle
    int spacing;      // expected ch0-to-ch0 write distance, 0 = not checked
    int expcnt;       // expected crossing count, -1 = model only
  } vec_t;

  logic [11:0] s0[1280];
  logic [11:0] s1[1280];

  task automatic run_frame(input vec_t v, input string tag);
    int dec    = (v.d == 1) ? 4 : 1;
    int npairs = (DEPTH - 1) * dec + 1;
    int i, t, got, bad, first, model_cnt, lastc1;
    bit hs;
    wr_t exp_q[$];
    int  kept_c[$];

    for (int n = 0; n < npairs; n++) begin
      case (v.pat)
        0:       begin s0[n] = 12'(n); s1[n] = 12'(n); end
        1:       begin s0[n] = (((n / dec) % 2) == 1) ? 12'h900 : 12'h700; s1[n] = 12'(n * 3); end
        default: begin s0[n] = 12'($urandom_range(0, 4095)); s1[n] = 12'($urandom); end
      endcase
    end

    wlog.delete(); fd_d.delete(); fd_c.delete(); hs_d.delete(); hs_c.delete();

    if (!v.skip_pulse) begin
      fs[v.d] = 1'b1;
      @(posedge clock); #1;
      fs[v.d] = 1'b0;
      chk({tag, " ready_after_frame_start"}, rdy[v.d], 1);
    end

    i = 0; t = 0;
    while (i < npairs && t < 20000) begin
      sv[v.d] = v.rv ? 1'($urandom_range(0, 1)) : 1'b1;
      c0[v.d] = s0[i];
      c1[v.d] = s1[i];
      fs[v.d] = v.mid_fs && (t == 150);
      @(negedge clock);
      hs = sv[v.d] & rdy[v.d];
      @(posedge clock); #1;
      if (hs) i++;
      t++;
    end
    sv[v.d] = 1'b0;
    fs[v.d] = 1'b0;
    chk({tag, " pairs_accepted"}, i, npairs);

    got = 0;
    for (int w = 0; w < 20 && got == 0; w++) begin
      if (fd[v.d]) begin
        got = 1;
        chk({tag, " busy_at_done"}, bz[v.d], 0);
        if (v.fs_on_done) begin
          fs[v.d] = 1'b1;
          @(posedge clock); #1;
          fs[v.d] = 1'b0;
          chk({tag, " ready_after_fs_on_done"}, rdy[v.d], 1);
        end
      end else begin
        @(posedge clock); #1;
      end
    end
    chk({tag, " frame_done_seen"}, got, 1);
    repeat (2) @(posedge clock);
    #1;

    // reference: point k holds accepted pair k*dec; count rising crossings between kept points
    model_cnt = 0;
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back('{v.d, CH0_BASE + 12'(k), {20'b0, s0[k * dec]}, 0});
      exp_q.push_back('{v.d, CH1_BASE + 12'(k), {20'b0, s1[k * dec]}, 0});
      if (k > 0 && s0[(k - 1) * dec] < THRESH && s0[k * dec] >= THRESH) model_cnt++;
    end
    if (model_cnt > 999) model_cnt = 999;
    if (HAS_VALUE) exp_q.push_back('{v.d, VALUE_ADDR, 32'(model_cnt), 0});

    chk({tag, " write_count"}, wlog.size(), exp_q.size());
    bad = 0; first = -1;
    for (int j = 0; j < wlog.size() && j < exp_q.size(); j++) begin
      if (wlog[j].d != exp_q[j].d || wlog[j].a != exp_q[j].a || wlog[j].v != exp_q[j].v) begin
        if (first < 0) first = j;
        bad++;
      end
    end
    chk($sformatf("%s write_log(first bad entry %0d)", tag, first), bad, 0);

    for (int j = 0; j < hs_d.size(); j++)
      if (hs_d[j] == v.d && ((kept_c.size() == 0 && j == 0) || 1)) kept_c.push_back(hs_c[j]);
    chk({tag, " handshakes"}, kept_c.size(), npairs);

    if (wlog.size() == exp_q.size() && kept_c.size() == npairs) begin
      bad = 0;
      for (int k = 0; k < DEPTH; k++) begin
        if (wlog[2 * k].c != kept_c[k * dec] + 1) bad++;
        if (wlog[2 * k + 1].c != wlog[2 * k].c + 1) bad++;
      end
      chk({tag, " write_timing_vs_handshake"}, bad, 0);
      if (v.spacing > 0) begin
        bad = 0;
        for (int k = 1; k < DEPTH; k++)
          if (wlog[2 * k].c - wlog[2 * k - 2].c != v.spacing) bad++;
        chk({tag, " ch0_write_spacing"}, bad, 0);
      end
      lastc1 = wlog[2 * DEPTH - 1].c;
      chk({tag, " done_pulses"}, fd_c.size(), 1);
      if (fd_c.size() >= 1) chk({tag, " done_latency"}, fd_c[0] - lastc1, DONE_LAT);
`ifdef SIGWR_CROSSING_EN
      chk({tag, " value_write_cycle"}, wlog[2 * DEPTH].c, lastc1 + 1);
      if (v.expcnt >= 0) chk({tag, " crossing_count"}, wlog[2 * DEPTH].v, v.expcnt);
      chk({tag, " count_le_999"}, (wlog[2 * DEPTH].v <= 999), 1);
`endif
    end
  endtask

  vec_t vt[8];

  initial begin
    int i, t;
    bit hs;
    vt[0] = '{d:0, pat:0, rv:1'b0, mid_fs:1'b0, skip_pulse:1'b0, fs_on_done:1'b0, spacing:3, expcnt:0};
    vt[1] = '{d:1, pat:0, rv:1'b0, mid_fs:1'b0, skip_pulse:1'b0, fs_on_done:1'b0, spacing:6, expcnt:0};
    vt[2] = '{d:0, pat:1, rv:1'b0, mid_fs:1'b0, skip_pulse:1'b0, fs_on_done:1'b1, spacing:3, expcnt:160};
    vt[3] = '{d:0, pat:0, rv:1'b0, mid_fs:1'b0, skip_pulse:1'b1, fs_on_done:1'b0, spacing:3, expcnt:0};
    vt[4] = '{d:0, pat:2, rv:1'b1, mid_fs:1'b1, skip_pulse:1'b0, fs_on_done:1'b0, spacing:0, expcnt:-1};
    vt[5] = '{d:1, pat:2, rv:1'b1, mid_fs:1'b1, skip_pulse:1'b0, fs_on_done:1'b0, spacing:0, expcnt:-1};
    vt[6] = '{d:0, pat:1, rv:1'b1, mid_fs:1'b0, skip_pulse:1'b0, fs_on_done:1'b0, spacing:0, expcnt:160};
    vt[7] = '{d:1, pat:1, rv:1'b0, mid_fs:1'b0, skip_pulse:1'b0, fs_on_done:1'b0, spacing:6, expcnt:160};

    reset = 1'b1; fs = '0; sv = 2'b11; c0 = '0; c1 = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    wlog.delete(); hs_d.delete(); hs_c.delete(); fd_c.delete(); fd_d.delete();
    repeat (5) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset dut%0d sample_ready", d), rdy[d], 0);
      chk($sformatf("reset dut%0d mem_wEn", d), wen[d], 0);
      chk($sformatf("reset dut%0d mem_addr", d), addr[d], 0);
      chk($sformatf("reset dut%0d mem_data", d), data[d], 0);
      chk($sformatf("reset dut%0d frame_done", d), fd[d], 0);
      chk($sformatf("reset dut%0d busy", d), bz[d], 0);
    end
    chk("idle writes", wlog.size(), 0);
    chk("idle handshakes", hs_d.size(), 0);
    sv = '0;

    for (int r = 0; r < 8; r++) run_frame(vt[r], $sformatf("row%0d", r));

    // reset in the middle of a frame, then a clean frame
    fs[0] = 1'b1;
    @(posedge clock); #1;
    fs[0] = 1'b0;
    i = 0; t = 0;
    while (i < 100 && t < 1000) begin
      sv[0] = 1'b1; c0[0] = 12'hA00; c1[0] = 12'(i);
      @(negedge clock);
      hs = sv[0] & rdy[0];
      @(posedge clock); #1;
      if (hs) i++;
      t++;
    end
    sv[0] = 1'b0;
    chk("midreset pairs_before_reset", i, 100);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midreset sample_ready", rdy[0], 0);
    chk("midreset mem_wEn", wen[0], 0);
    chk("midreset mem_addr", addr[0], 0);
    chk("midreset mem_data", data[0], 0);
    chk("midreset frame_done", fd[0], 0);
    chk("midreset busy", bz[0], 0);
    reset = 1'b0;
    @(posedge clock); #1;
    run_frame('{d:0, pat:1, rv:1'b0, mid_fs:1'b0, skip_pulse:1'b0, fs_on_done:1'b0, spacing:3, expcnt:160}, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
